// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared FSM encoding, length type and payload limit for the UDP TX payload path
package udp_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;
    typedef logic [15:0] len_t;
    localparam int UDP_MAX_PAYLOAD = 1472;
    function automatic len_t min_len(input len_t a, input len_t b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/udp_flush_timer.sv
// udp_flush_timer: saturating idle timer that flags when a short-packet flush is due
//   clk, tb_rst : clock, async active-high reset
//   en          : count one cycle (stops at TIMEOUT_CYC)
//   clr         : return to zero, wins over en
//   hit         : count has reached TIMEOUT_CYC
module udp_flush_timer
    import udp_tx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic tb_rst,
    input  logic en,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] cnt;
    assign hit = cnt == W'(TIMEOUT_CYC);
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !hit) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/udp_tx_payload_reader.sv
// udp_tx_payload_reader: decides when a UDP payload is ready in the TX FIFO and drains it to the UDP core
//   clk, tb_rst                        : clock, async active-high reset
//   fifo_rd_en / fifo_rd_data          : FIFO read strobe, data valid one cycle later
//   fifo_rd_empty, fifo_rd_water_level : FIFO status
//   udp_tx_ready, udp_tx_data_req      : core idle, core byte request
//   udp_tx_start, udp_tx_len           : frame-start pulse and payload length
//   udp_tx_data, _valid, _last         : payload byte stream
//   underflow_err                      : sticky, request seen with FIFO empty mid-frame
//   pkt_cnt                            : frames sent, wraps
module udp_tx_payload_reader
    import udp_tx_pkg::*;
#(
    parameter int DEPTH_WIDTH = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int PKT_LEN     = 1024,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
    input  logic                   udp_tx_ready,
    output logic                   udp_tx_start,
    output logic [15:0]            udp_tx_len,
    input  logic                   udp_tx_data_req,
    output logic [DATA_WIDTH-1:0]  udp_tx_data,
    output logic                   udp_tx_data_valid,
    output logic                   udp_tx_last,
    output logic                   underflow_err,
    output logic [15:0]            pkt_cnt
);
    localparam len_t PKT = len_t'(PKT_LEN > UDP_MAX_PAYLOAD ? UDP_MAX_PAYLOAD : PKT_LEN);
    state_t state;
    len_t   remain;
    len_t   level;
    logic   timer_hit;
    assign level = len_t'(fifo_rd_water_level);
    assign fifo_rd_en = (state == SEND) && udp_tx_data_req && (remain != '0) && !fifo_rd_empty;
    // FIFO output is passed straight through; gated so the bus reads 0 outside valid bytes
    assign udp_tx_data = udp_tx_data_valid ? fifo_rd_data : '0;
    udp_flush_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .tb_rst (tb_rst),
        .en     (state == IDLE && level != '0),
        .clr    (state != IDLE || level == '0),
        .hit    (timer_hit)
    );
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state             <= IDLE;
            remain            <= '0;
            udp_tx_start      <= 1'b0;
            udp_tx_len        <= '0;
            udp_tx_data_valid <= 1'b0;
            udp_tx_last       <= 1'b0;
            underflow_err     <= 1'b0;
            pkt_cnt           <= '0;
        end else begin
            udp_tx_start      <= 1'b0;
            udp_tx_data_valid <= fifo_rd_en;
            udp_tx_last       <= fifo_rd_en && remain == 16'd1;
            case (state)
                IDLE: begin
                    // full packet takes precedence; a timeout flush only sends what is buffered
                    if (udp_tx_ready && (level >= PKT || (timer_hit && level != '0))) begin
                        udp_tx_len   <= min_len(level, PKT);
                        udp_tx_start <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    remain <= udp_tx_len;
                    state  <= SEND;
                end
                SEND: begin
                    if (fifo_rd_en) remain <= remain - 16'd1;
                    if (udp_tx_data_req && remain != '0 && fifo_rd_empty) underflow_err <= 1'b1;
                    // leave once the final byte is actually on the bus
                    if (udp_tx_last) state <= DONE;
                end
                DONE: begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_payload_reader.sv
// tb_udp_tx_payload_reader: directed self-checking bench with a behavioural 4096x8 FIFO
`timescale 1ns/1ps
module tb_udp_tx_payload_reader;
    localparam int TO = 1500;
    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_empty;
    logic [12:0] fifo_rd_water_level;
    logic        udp_tx_ready;
    logic        udp_tx_start;
    logic [15:0] udp_tx_len;
    logic        udp_tx_data_req;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_data_valid;
    logic        udp_tx_last;
    logic        underflow_err;
    logic [15:0] pkt_cnt;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  mem [4096];
    logic [12:0] wptr, rptr;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx [$];
    int          lens [$];
    int          lasts [$];
    int          starts [$];
    int          n_start, n_last, lat_err, fb, first_cyc, last_cyc, min_gap;
    logic        prev_rd;

    always #5 clk = ~clk;

    udp_tx_payload_reader #(
        .DEPTH_WIDTH(12), .DATA_WIDTH(8), .PKT_LEN(1024), .TIMEOUT_CYC(TO)
    ) dut (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .udp_tx_ready        (udp_tx_ready),
        .udp_tx_start        (udp_tx_start),
        .udp_tx_len          (udp_tx_len),
        .udp_tx_data_req     (udp_tx_data_req),
        .udp_tx_data         (udp_tx_data),
        .udp_tx_data_valid   (udp_tx_data_valid),
        .udp_tx_last         (udp_tx_last),
        .underflow_err       (underflow_err),
        .pkt_cnt             (pkt_cnt)
    );

    assign fifo_rd_water_level = wptr - rptr;
    assign fifo_rd_empty = wptr == rptr;
    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wptr <= '0;
            rptr <= '0;
            fifo_rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[11:0]] <= wr_data;
                wptr <= wptr + 13'd1;
            end
            if (fifo_rd_en) begin
                fifo_rd_data <= mem[rptr[11:0]];
                rptr <= rptr + 13'd1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (tb_rst) begin
            n_start = 0; n_last = 0; lat_err = 0; fb = 0; first_cyc = 0;
            last_cyc = -100; min_gap = 1 << 30; prev_rd = 1'b0;
            rx.delete(); lens.delete(); lasts.delete(); starts.delete();
        end else begin
            if (udp_tx_data_valid !== prev_rd) lat_err++;
            prev_rd = fifo_rd_en;
            if (udp_tx_start) begin
                if (n_start > 0 && cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                n_start++;
                starts.push_back(cyc);
                lens.push_back(int'(udp_tx_len));
                fb = 0;
            end
            if (udp_tx_data_valid) begin
                if (fb == 0) first_cyc = cyc;
                fb++;
                rx.push_back(udp_tx_data);
                last_cyc = cyc;
                if (udp_tx_last) begin
                    n_last++;
                    lasts.push_back(fb);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int data_errs();
        int e = 0;
        for (int i = 0; i < rx.size(); i++)
            if (i >= exp_q.size() || rx[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic do_reset();
        tb_rst = 1'b1;
        wr_en = 1'b0;
        udp_tx_ready = 1'b0;
        udp_tx_data_req = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 tb_rst = 1'b0;
    endtask

    task automatic write_bytes(input int n, input int first, input int step);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) wr0 = cyc;
            wr_en = 1'b1;
            wr_data = 8'(first + step * i);
            exp_q.push_back(wr_data);
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_pkt(input string tag, input int n, input int budget);
        int k = 0;
        while (pkt_cnt != 16'(n) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, int'(pkt_cnt), n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        int k;
        wr_en = 1'b0;
        wr_data = '0;
        udp_tx_ready = 1'b0;
        udp_tx_data_req = 1'b0;
        do_reset();
        check("rst_start", udp_tx_start, 0);
        check("rst_len", int'(udp_tx_len), 0);
        check("rst_valid", udp_tx_data_valid, 0);
        check("rst_last", udp_tx_last, 0);
        check("rst_data", int'(udp_tx_data), 0);
        check("rst_underflow", underflow_err, 0);
        check("rst_pkt_cnt", int'(pkt_cnt), 0);
        check("rst_rd_en", fifo_rd_en, 0);

        // full 1024-byte packet, descending pattern, request held high
        udp_tx_ready = 1'b1;
        udp_tx_data_req = 1'b1;
        write_bytes(1024, 8'hFF, -1);
        wait_pkt("t1_pkt_cnt", 1, 3000);
        check("t1_starts", n_start, 1);
        check("t1_len", at(lens, 0), 1024);
        check("t1_bytes", rx.size(), 1024);
        check("t1_data", data_errs(), 0);
        check("t1_lasts", n_last, 1);
        check("t1_last_pos", at(lasts, 0), 1024);
        check("t1_first_lat", first_cyc - at(starts, 0), 2);
        check("t1_span", last_cyc - first_cyc, 1023);
        check("t1_rd_lat", lat_err, 0);
        check("t1_underflow", underflow_err, 0);

        // short packet flushed by the timeout
        do_reset();
        udp_tx_ready = 1'b1;
        udp_tx_data_req = 1'b1;
        write_bytes(10, 8'h10, 3);
        wait_pkt("t2_pkt_cnt", 1, TO + 100);
        check("t2_start_delay", at(starts, 0) - wr0, TO + 2);
        check("t2_len", at(lens, 0), 10);
        check("t2_bytes", rx.size(), 10);
        check("t2_data", data_errs(), 0);
        check("t2_last_pos", at(lasts, 0), 10);

        // 3000 bytes: two full frames then a 952-byte flush
        do_reset();
        udp_tx_ready = 1'b1;
        udp_tx_data_req = 1'b1;
        write_bytes(3000, 0, 1);
        wait_pkt("t3_pkt_cnt", 3, TO + 2000);
        check("t3_starts", n_start, 3);
        check("t3_len0", at(lens, 0), 1024);
        check("t3_len1", at(lens, 1), 1024);
        check("t3_len2", at(lens, 2), 952);
        check("t3_last0", at(lasts, 0), 1024);
        check("t3_last1", at(lasts, 1), 1024);
        check("t3_last2", at(lasts, 2), 952);
        check("t3_bytes", rx.size(), 3000);
        check("t3_data", data_errs(), 0);
        check("t3_min_gap", min_gap, 3);
        check("t3_rd_lat", lat_err, 0);

        // request toggling every cycle
        do_reset();
        write_bytes(1024, 1, 7);
        check("t4_no_start_unready", n_start, 0);
        udp_tx_ready = 1'b1;
        k = 0;
        while (pkt_cnt != 16'd1 && k < 4000) begin
            @(posedge clk);
            #1 udp_tx_data_req = ~udp_tx_data_req;
            k++;
        end
        udp_tx_data_req = 1'b0;
        wait_pkt("t4_pkt_cnt", 1, 10);
        check("t4_starts", n_start, 1);
        check("t4_bytes", rx.size(), 1024);
        check("t4_data", data_errs(), 0);
        check("t4_last_pos", at(lasts, 0), 1024);
        check("t4_rd_lat", lat_err, 0);

        // core not ready with 2048 bytes buffered, then ready rises
        do_reset();
        udp_tx_data_req = 1'b1;
        write_bytes(2048, 8'hA5, 11);
        repeat (TO + 50) @(posedge clk);
        #1;
        check("t5_no_start", n_start, 0);
        udp_tx_ready = 1'b1;
        r = cyc;
        wait_pkt("t5_pkt_cnt", 2, 3000);
        check("t5_start_lat", at(starts, 0) - r, 1);
        check("t5_len0", at(lens, 0), 1024);
        check("t5_len1", at(lens, 1), 1024);
        check("t5_bytes", rx.size(), 2048);
        check("t5_data", data_errs(), 0);
        check("t5_min_gap", min_gap, 3);

        // reset in the middle of a frame, then a clean frame
        write_bytes(1024, 8'h5A, 13);
        k = 0;
        while (!(n_start == 3 && fb >= 500) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check("t6_reached_mid", int'(n_start == 3 && fb >= 500), 1);
        #2 tb_rst = 1'b1;
        #1;
        check("t6_rst_start", udp_tx_start, 0);
        check("t6_rst_valid", udp_tx_data_valid, 0);
        check("t6_rst_data", int'(udp_tx_data), 0);
        check("t6_rst_last", udp_tx_last, 0);
        check("t6_rst_len", int'(udp_tx_len), 0);
        check("t6_rst_pkt_cnt", int'(pkt_cnt), 0);
        check("t6_rst_rd_en", fifo_rd_en, 0);
        do_reset();
        udp_tx_ready = 1'b1;
        udp_tx_data_req = 1'b1;
        write_bytes(1024, 8'hC3, 5);
        wait_pkt("t6_pkt_cnt", 1, 3000);
        check("t6_starts", n_start, 1);
        check("t6_len", at(lens, 0), 1024);
        check("t6_bytes", rx.size(), 1024);
        check("t6_data", data_errs(), 0);
        check("t6_last_pos", at(lasts, 0), 1024);
        check("t6_underflow", underflow_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
